// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller: FSM states,
// instruction classes, opcode/op values and IR field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WR_IMM = 3'd2,
    ST_GET_A  = 3'd3,
    ST_GET_B  = 3'd4,
    ST_ALU    = 3'd5,
    ST_WR_REG = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOVIMM  = 3'd0,
    CLS_MOVREG  = 3'd1,
    CLS_ALU     = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_ILLEGAL = 3'd4
  } instr_class_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] ALU_ADD    = 2'b00;

  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned OP_LSB  = 11;
  localparam int unsigned RN_LSB  = 8;
  localparam int unsigned RD_LSB  = 5;
  localparam int unsigned SH_LSB  = 3;
  localparam int unsigned RM_LSB  = 0;

  function automatic logic [15:0] ext_imm8(input logic [7:0] imm, input logic sext);
    return sext ? {{8{imm[7]}}, imm} : {8'b0, imm};
  endfunction

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift/op
// fields, classifies the instruction and produces the extended immediate.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter logic IMM_SEXT = 1'b1
) (
  input  logic [15:0]  ir_i,
  output logic [2:0]   rn_o,
  output logic [2:0]   rd_o,
  output logic [2:0]   rm_o,
  output logic [1:0]   sh_o,
  output logic [1:0]   op_o,
  output logic [15:0]  imm_o,
  output instr_class_t cls_o
);

  logic [2:0] opc;

  assign opc   = ir_i[OPC_LSB +: 3];
  assign op_o  = ir_i[OP_LSB +: 2];
  assign rn_o  = ir_i[RN_LSB +: 3];
  assign rd_o  = ir_i[RD_LSB +: 3];
  assign sh_o  = ir_i[SH_LSB +: 2];
  assign rm_o  = ir_i[RM_LSB +: 3];
  assign imm_o = ext_imm8(ir_i[7:0], IMM_SEXT);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opc == OPC_MOV && op_o == OP_MOVIMM) begin
      cls_o = CLS_MOVIMM;
    end else if (opc == OPC_MOV && op_o == OP_MOVREG) begin
      cls_o = CLS_MOVREG;
    end else if (opc == OPC_ALU) begin
      cls_o = (op_o == OP_CMP) ? CLS_CMP : CLS_ALU;
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM sequencing the datapath's
// regfile, A/B/C/status enables and mux selects for each instruction.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter logic IMM_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic        wb_sel,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status
);

  state_t       state_q, state_d;
  logic [15:0]  ir_q, ir_d;

  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh, op;
  instr_class_t cls;

  instr_decoder #(.IMM_SEXT(IMM_SEXT)) u_dec (
    .ir_i  (ir_q),
    .rn_o  (rn),
    .rd_o  (rd),
    .rm_o  (rm),
    .sh_o  (sh),
    .op_o  (op),
    .imm_o (datapath_in),
    .cls_o (cls)
  );

  // IR only changes in WAIT; a same-cycle load&s lets DECODE see the new word.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CLS_MOVIMM: state_d = ST_WR_IMM;
          CLS_MOVREG: state_d = ST_GET_B;
          CLS_ALU,
          CLS_CMP:    state_d = ST_GET_A;
          default:    state_d = ST_WAIT;
        endcase
      end
      ST_WR_IMM: state_d = ST_WAIT;
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_ALU;
      ST_ALU:    state_d = (cls == CLS_CMP) ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    w         = 1'b0;
    wb_sel    = 1'b0;
    w_addr    = '0;
    w_en      = 1'b0;
    r_addr    = '0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    shift_op  = '0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    ALU_op    = '0;
    en_C      = 1'b0;
    en_status = 1'b0;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_WR_IMM: begin
        wb_sel = 1'b1;
        w_addr = rn;
        w_en   = 1'b1;
      end
      ST_GET_A: begin
        r_addr = rn;
        en_A   = 1'b1;
      end
      ST_GET_B: begin
        r_addr = rm;
        en_B   = 1'b1;
      end
      ST_ALU: begin
        shift_op = sh;
        if (cls == CLS_MOVREG) begin
          sel_A  = 1'b1;
          ALU_op = ALU_ADD;
        end else begin
          ALU_op = op;
        end
        if (cls == CLS_CMP) en_status = 1'b1;
        else                en_C      = 1'b1;
      end
      ST_WR_REG: begin
        w_addr = rd;
        w_en   = 1'b1;
      end
      default: ;
    endcase
    // Reset gates every enable so an interrupted instruction cannot commit.
    if (reset) begin
      w_en      = 1'b0;
      en_A      = 1'b0;
      en_B      = 1'b0;
      en_C      = 1'b0;
      en_status = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: table of spec instructions, reset/ignore corner
// sequences, and randomized instructions against a phase-list reference model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in_r;

  logic        w0, wbs0, we0, ea0, eb0, sa0, sb0, ec0, es0;
  logic [15:0] dp0;
  logic [2:0]  wa0, ra0;
  logic [1:0]  sh0, alu0;
  logic        w1, wbs1, we1, ea1, eb1, sa1, sb1, ec1, es1;
  logic [15:0] dp1;
  logic [2:0]  wa1, ra1;
  logic [1:0]  sh1, alu1;

  always #5 clk = ~clk;

  cpu_controller #(.IMM_SEXT(1'b1)) dut (
    .clk(clk), .reset(reset), .in(in_r), .load(load), .s(s),
    .w(w0), .datapath_in(dp0), .wb_sel(wbs0), .w_addr(wa0), .w_en(we0),
    .r_addr(ra0), .en_A(ea0), .en_B(eb0), .shift_op(sh0), .sel_A(sa0),
    .sel_B(sb0), .ALU_op(alu0), .en_C(ec0), .en_status(es0)
  );

  cpu_controller #(.IMM_SEXT(1'b0)) dut_z (
    .clk(clk), .reset(reset), .in(in_r), .load(load), .s(s),
    .w(w1), .datapath_in(dp1), .wb_sel(wbs1), .w_addr(wa1), .w_en(we1),
    .r_addr(ra1), .en_A(ea1), .en_B(eb1), .shift_op(sh1), .sel_A(sa1),
    .sel_B(sb1), .ALU_op(alu1), .en_C(ec1), .en_status(es1)
  );

  typedef struct packed {
    logic        w;
    logic [15:0] dp;
    logic        wb_sel;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic        en_A;
    logic        en_B;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  alu_op;
    logic        en_C;
    logic        en_status;
  } outs_t;

  outs_t act0, act1;
  assign act0 = {w0, dp0, wbs0, wa0, we0, ra0, ea0, eb0, sh0, sa0, sb0, alu0, ec0, es0};
  assign act1 = {w1, dp1, wbs1, wa1, we1, ra1, ea1, eb1, sh1, sa1, sb1, alu1, ec1, es1};

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_ir;
  int ph_q[$];

  // Phases: 0 idle, 1 decode, 2 write imm, 3 read Rn, 4 read Rm, 5 alu, 6 write Rd
  localparam int PH_IDLE = 0, PH_DEC = 1, PH_WRI = 2, PH_RA = 3, PH_RB = 4, PH_EXE = 5, PH_WRR = 6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ir=%h: got %h expected %h", nm, model_ir, act, exp);
    end
  endtask

  function automatic outs_t exp_out(input int ph, input logic [15:0] ir, input bit sext);
    outs_t o;
    int opc, op, imm;
    o   = '0;
    opc = int'(ir) / 8192;
    op  = (int'(ir) / 2048) % 4;
    imm = int'(ir) % 256;
    o.dp = (sext && imm >= 128) ? 16'(imm + 65280) : 16'(imm);
    case (ph)
      PH_IDLE: o.w = 1'b1;
      PH_WRI: begin
        o.wb_sel = 1'b1;
        o.w_addr = 3'((int'(ir) / 256) % 8);
        o.w_en   = 1'b1;
      end
      PH_RA: begin
        o.r_addr = 3'((int'(ir) / 256) % 8);
        o.en_A   = 1'b1;
      end
      PH_RB: begin
        o.r_addr = 3'(int'(ir) % 8);
        o.en_B   = 1'b1;
      end
      PH_EXE: begin
        o.shift_op = 2'((int'(ir) / 8) % 4);
        if (opc == 6) begin
          o.sel_A  = 1'b1;
          o.alu_op = 2'd0;
        end else begin
          o.alu_op = 2'(op);
        end
        if (opc == 5 && op == 1) o.en_status = 1'b1;
        else                     o.en_C      = 1'b1;
      end
      PH_WRR: begin
        o.w_addr = 3'((int'(ir) / 32) % 8);
        o.w_en   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic plan(input logic [15:0] ir);
    int opc, op;
    opc = int'(ir) / 8192;
    op  = (int'(ir) / 2048) % 4;
    ph_q.delete();
    ph_q.push_back(PH_DEC);
    if (opc == 6 && op == 2) begin
      ph_q.push_back(PH_WRI);
    end else if (opc == 6 && op == 0) begin
      ph_q.push_back(PH_RB); ph_q.push_back(PH_EXE); ph_q.push_back(PH_WRR);
    end else if (opc == 5) begin
      ph_q.push_back(PH_RA); ph_q.push_back(PH_RB); ph_q.push_back(PH_EXE);
      if (op != 1) ph_q.push_back(PH_WRR);
    end
    ph_q.push_back(PH_IDLE);
  endtask

  // Walks the planned phases, junking load/s/in on every non-idle cycle.
  task automatic run_trace();
    for (int i = 0; i < ph_q.size(); i++) begin
      chk("trace_sext", act0, exp_out(ph_q[i], model_ir, 1'b1));
      chk("trace_zext", act1, exp_out(ph_q[i], model_ir, 1'b0));
      if (i == ph_q.size() - 1) begin
        load = 1'b0;
        s    = 1'b0;
      end else begin
        load = 1'($urandom);
        s    = 1'($urandom);
        in_r = 16'($urandom);
        tick();
      end
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    int          cycles;
    int          wes;
    logic [2:0]  waddr;
    logic [15:0] dp_s;
    logic [15:0] dp_z;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, wes;
    logic [2:0] wa;
    logic [15:0] ins;
    logic [15:0] r;
    int m;

    tbl[0] = '{16'hD205, 2, 1, 3'd2, 16'h0005, 16'h0005};
    tbl[1] = '{16'hD1FD, 2, 1, 3'd1, 16'hFFFD, 16'h00FD};
    tbl[2] = '{16'hA261, 5, 1, 3'd3, 16'h0061, 16'h0061};
    tbl[3] = '{16'hAA01, 4, 0, 3'd0, 16'h0001, 16'h0001};
    tbl[4] = '{16'hC088, 4, 1, 3'd4, 16'hFF88, 16'h0088};
    tbl[5] = '{16'hE000, 1, 0, 3'd0, 16'h0000, 16'h0000};

    reset = 1'b1; load = 1'b0; s = 1'b0; in_r = '0;
    model_ir = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_state", act0, exp_out(PH_IDLE, 16'h0000, 1'b1));

    foreach (tbl[k]) begin
      in_r = tbl[k].instr; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      model_ir = tbl[k].instr;
      chk("tbl_dp_sext", dp0, tbl[k].dp_s);
      chk("tbl_dp_zext", dp1, tbl[k].dp_z);
      n = 0; wes = 0; wa = '0;
      while (w0 !== 1'b1 && n < 20) begin
        if (we0 === 1'b1) begin
          wes++;
          wa = wa0;
        end
        tick();
        n++;
      end
      chk("tbl_cycles", n, tbl[k].cycles);
      chk("tbl_wen_pulses", wes, tbl[k].wes);
      chk("tbl_waddr", wa, tbl[k].waddr);
    end

    // Reset while reading Rm of an ADD.
    in_r = 16'hA261; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0; model_ir = 16'hA261;
    tick(); tick();
    chk("pre_reset_getb", {ea0, eb0, ec0, we0, es0}, 5'b01000);
    reset = 1'b1;
    #1;
    chk("reset_gates_en", {ea0, eb0, ec0, we0, es0}, 5'b00000);
    tick();
    model_ir = '0;
    chk("reset_to_wait", act0, exp_out(PH_IDLE, 16'h0000, 1'b1));
    reset = 1'b0;
    tick();
    chk("idle_after_reset", act0, exp_out(PH_IDLE, 16'h0000, 1'b1));

    for (int it = 0; it < 300; it++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins = {3'b110, 2'b10, r[10:0]};
        1: ins = {3'b110, 2'b00, r[10:0]};
        2: ins = {3'b101, r[12:0]};
        default: ins = r;
      endcase
      m = int'($urandom_range(0, 2));
      if (m == 0) begin
        in_r = ins; load = 1'b1; s = 1'b1;
        tick();
        model_ir = ins;
      end else if (m == 1) begin
        in_r = ins; load = 1'b1; s = 1'b0;
        tick();
        model_ir = ins;
        chk("load_only", act0, exp_out(PH_IDLE, model_ir, 1'b1));
        load = 1'b0; in_r = 16'($urandom); s = 1'b1;
        tick();
      end else begin
        load = 1'b0; in_r = ins; s = 1'b1;
        tick();
      end
      plan(model_ir);
      run_trace();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
